// File: rtl/alu_serial.sv
// Digit-serial AND/OR/ADD/SUB ALU: operands are consumed DIGIT bits per clock, LSB first,
// through a chain of 1-bit slices with a registered carry between digits.

module alu_slice (
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic [1:0] op,
    output logic       y,
    output logic       co
);
    always_comb begin
        co = (a & b) | (cin & (a ^ b));
        unique case (op)
            2'b00:   y = a & b;
            2'b01:   y = a | b;
            default: y = a ^ b ^ cin;
        endcase
    end
endmodule

module alu_serial #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             zero,
    output logic             overflow
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_next;
    logic [1:0]       op_r;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             arith, sub, last;
    logic [DIGIT-1:0] b_eff, y;
    logic [DIGIT:0]   c;

    assign arith = op_r[1];
    assign sub   = op_r[1] & op_r[0];
    assign b_eff = b_sr[DIGIT-1:0] ^ {DIGIT{sub}};
    assign c[0]  = carry;
    assign last  = (cnt == CW'(N - 1));

    genvar i;
    generate
        for (i = 0; i < DIGIT; i++) begin : g_slice
            alu_slice u_slice (
                .a   (a_sr[i]),
                .b   (b_eff[i]),
                .cin (c[i]),
                .op  (op_r),
                .y   (y[i]),
                .co  (c[i+1])
            );
        end
    endgenerate

    // New digit enters from the MSB side; after N digits the LSB digit has reached bit 0.
    assign res_next = WIDTH'({y, res_sr} >> DIGIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            cout     <= 1'b0;
            zero     <= 1'b0;
            overflow <= 1'b0;
            a_sr     <= '0;
            b_sr     <= '0;
            res_sr   <= '0;
            op_r     <= 2'b00;
            cnt      <= '0;
            carry    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        op_r  <= op;
                        cnt   <= '0;
                        carry <= (op == 2'b11);
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> DIGIT;
                    b_sr   <= b_sr >> DIGIT;
                    res_sr <= res_next;
                    carry  <= c[DIGIT];
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        state    <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        result   <= res_next;
                        zero     <= (res_next == '0);
                        cout     <= arith & c[DIGIT];
                        overflow <= arith & (c[DIGIT] ^ c[DIGIT-1]);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
